core_switch: RTL and testbench
==============================

Name: core_switch

Overview:
- Point-to-point data crossbar connecting CORE_SIZE compute cores (matrix and vector cores) in the processor array.
- Each core may offer one WIDTH-element vector of single-precision floats to a named destination core. Each core may also request one vector from a named source core.
- A transfer completes only when a sender and a receiver name each other. The switch then registers the data into the receiver's output and pulses completion flags to both sides.

Parameters:
- WIDTH, 64, number of 32-bit float elements per transferred vector.
- CORE_SIZE, 8, number of attached cores (ports per side).
- CORE_ADDR_SIZE, $clog2(CORE_SIZE), width of a core index. Derived; not overridden.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- send_ready  input  [CORE_SIZE] x 1  core i has data offered for sending.
- send_core_idx  input  [CORE_SIZE] x CORE_ADDR_SIZE  destination core index for sender i.
- send_data  input  [CORE_SIZE][WIDTH] x shortreal (32-bit IEEE-754)  vector offered by sender i.
- send_ok  output  [CORE_SIZE] x 1  one-cycle pulse: sender i's data was delivered.
- recv_request  input  [CORE_SIZE] x 1  core j wants to receive.
- recv_core_idx  input  [CORE_SIZE] x CORE_ADDR_SIZE  source core index receiver j accepts from.
- recv_ready  output  [CORE_SIZE] x 1  one-cycle pulse: recv_data[j] holds newly delivered data.
- recv_data  output  [CORE_SIZE][WIDTH] x shortreal  last vector delivered to receiver j.

Behaviour:
- Match condition for pair (i, j), evaluated combinationally each cycle:
  - send_ready[i] and recv_request[j] are both high;
  - send_core_idx[i] == j and recv_core_idx[j] == i;
  - send_ok[i] is currently low and recv_ready[j] is currently low.
  - The last two terms form an eligibility guard. It prevents a duplicate transfer while the cores are still reacting to the previous completion pulse.
- Uniqueness: each sender names one destination and each receiver names one source, so at most one match exists per sender and per receiver. No arbitration is needed. All matching pairs transfer in the same cycle, in parallel.
- On a rising edge with a match (i, j) and reset low:
  - recv_data[j] <= send_data[i], all WIDTH elements, bit-exact copy with no arithmetic;
  - recv_ready[j] <= 1;
  - send_ok[i] <= 1.
- On a rising edge with no match involving sender i, send_ok[i] <= 0. Likewise recv_ready[j] <= 0 for an unmatched receiver j. Both flags are therefore single-cycle pulses.
- recv_data[j] holds its value until the next transfer into j or until reset.
- Latency: the match is present in cycle N; send_ok, recv_ready and recv_data become visible in cycle N+1.
  - Cores must deassert send_ready / recv_request on the edge ending cycle N+1.
  - The guard forces cycle N+1 to be idle for that pair. The minimum repeat interval per pair is 2 cycles.
- Self-transfer (i == j, both indices pointing at itself) is legal and behaves identically.
- An index value ≥ CORE_SIZE (non-power-of-two CORE_SIZE) never matches.
- One-sided requests: a send without a matching receive, or a receive without a matching send, waits indefinitely with no outputs changing. Two senders targeting the same receiver are resolved only by that receiver's recv_core_idx. The non-selected sender keeps waiting.
- Reset: on a rising edge with reset high, all send_ok = 0, all recv_ready = 0 and all recv_data elements = 0.0. Reset dominates any simultaneous match. A transfer pending when reset asserts is dropped, and no pulses are emitted for it.
- Changing send_data in the same cycle as the match is permitted. The value present at the capturing edge is delivered.

Test Plan:
- Reset: hold reset 1 cycle with random inputs -> all send_ok = 0, recv_ready = 0, recv_data = 0.0 next cycle.
- Basic transfer: core 0 sends to 5 with data[k] = k+0.5; core 5 requests from 0 -> one cycle later send_ok[0] = 1, recv_ready[5] = 1, recv_data[5][k] = k+0.5; both pulses 0 in the following cycle.
- Held handshake: keep both requests asserted for 4 cycles -> pulses high on cycles 1 and 3 only (2-cycle interval). recv_data[5] updates only on those cycles.
- Mismatch: core 1 sends to 6 while core 6 requests from 2 -> no pulses for 10 cycles. Then core 2 sends to 6 with data = 3.25 -> recv_data[6] = 3.25 and send_ok[2] = 1; send_ok[1] stays 0.
- Parallel: pairs 0→4, 1→5, 2→6, 3→7 plus self-transfer 7→7 request rejected, since 7 receives from 3 -> four simultaneous deliveries in one cycle, each receiver getting its own source's data.
- Reset mid-operation: match asserted in the same cycle as reset -> no pulses, recv_data = 0.0. After reset deasserts with the requests still held -> transfer completes normally.

Source files
------------

// File: rtl/core_switch.sv
// Point-to-point vector crossbar: a transfer fires when sender i names receiver j
// and receiver j names sender i; data and completion pulses are registered.
module core_switch #(
  parameter int unsigned WIDTH          = 64,
  parameter int unsigned CORE_SIZE      = 8,
  parameter int unsigned CORE_ADDR_SIZE = $clog2(CORE_SIZE)
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic [CORE_SIZE-1:0]                         send_ready,
  input  logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0]     send_core_idx,
  input  logic [CORE_SIZE-1:0][WIDTH-1:0][31:0]        send_data,
  output logic [CORE_SIZE-1:0]                         send_ok,
  input  logic [CORE_SIZE-1:0]                         recv_request,
  input  logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0]     recv_core_idx,
  output logic [CORE_SIZE-1:0]                         recv_ready,
  output logic [CORE_SIZE-1:0][WIDTH-1:0][31:0]        recv_data
);

  logic [CORE_SIZE-1:0]                  send_hit;
  logic [CORE_SIZE-1:0]                  recv_hit;
  logic [CORE_SIZE-1:0][WIDTH-1:0][31:0] recv_mux;

  // Mutual-naming match; each receiver names one source, so at most one sender
  // can hit a given receiver and the mux needs no priority.
  always_comb begin
    send_hit = '0;
    recv_hit = '0;
    recv_mux = '0;
    for (int j = 0; j < int'(CORE_SIZE); j++) begin
      for (int i = 0; i < int'(CORE_SIZE); i++) begin
        if (send_ready[i] && recv_request[j] &&
            (send_core_idx[i] == CORE_ADDR_SIZE'(j)) &&
            (recv_core_idx[j] == CORE_ADDR_SIZE'(i)) &&
            !send_ok[i] && !recv_ready[j]) begin
          send_hit[i] = 1'b1;
          recv_hit[j] = 1'b1;
          recv_mux[j] = send_data[i];
        end
      end
    end
  end

  // Pulses last one cycle; the guard above keeps the following cycle idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      send_ok    <= '0;
      recv_ready <= '0;
      recv_data  <= '0;
    end else begin
      send_ok    <= send_hit;
      recv_ready <= recv_hit;
      for (int j = 0; j < int'(CORE_SIZE); j++) begin
        if (recv_hit[j]) begin
          recv_data[j] <= recv_mux[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_core_switch.sv
// Directed bench for core_switch: receiver-centric reference model compared every
// cycle, plus literal expectations for each scenario.
module tb_core_switch;
  localparam int unsigned W  = 64;
  localparam int unsigned CS = 8;
  localparam int unsigned AW = $clog2(CS);

  logic                          clock = 1'b0;
  logic                          reset;
  logic [CS-1:0]                 send_ready;
  logic [CS-1:0][AW-1:0]         send_core_idx;
  logic [CS-1:0][W-1:0][31:0]    send_data;
  logic [CS-1:0]                 send_ok;
  logic [CS-1:0]                 recv_request;
  logic [CS-1:0][AW-1:0]         recv_core_idx;
  logic [CS-1:0]                 recv_ready;
  logic [CS-1:0][W-1:0][31:0]    recv_data;

  core_switch #(.WIDTH(W), .CORE_SIZE(CS)) dut (
    .clock(clock), .reset(reset),
    .send_ready(send_ready), .send_core_idx(send_core_idx), .send_data(send_data),
    .send_ok(send_ok),
    .recv_request(recv_request), .recv_core_idx(recv_core_idx),
    .recv_ready(recv_ready), .recv_data(recv_data)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  // Reference model state
  logic [CS-1:0]              m_ok  = '0;
  logic [CS-1:0]              m_rdy = '0;
  logic [CS-1:0][W-1:0][31:0] m_data = '0;

  // Each requesting receiver looks up its named source and checks it points back.
  always @(posedge clock) begin
    logic [CS-1:0] nxt_ok;
    logic [CS-1:0] nxt_rdy;
    int s;
    if (reset) begin
      m_ok = '0; m_rdy = '0; m_data = '0;
    end else begin
      nxt_ok = '0; nxt_rdy = '0;
      for (int j = 0; j < int'(CS); j++) begin
        s = int'(recv_core_idx[j]);
        if (recv_request[j] && s < int'(CS)) begin
          if (send_ready[s] && int'(send_core_idx[s]) == j && !m_ok[s] && !m_rdy[j]) begin
            nxt_ok[s]  = 1'b1;
            nxt_rdy[j] = 1'b1;
            m_data[j]  = send_data[s];
          end
        end
      end
      m_ok = nxt_ok; m_rdy = nxt_rdy;
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      n_tests++;
      if (send_ok !== m_ok) begin
        n_fail++; $display("FAIL model_send_ok t=%0t got %b want %b", $time, send_ok, m_ok);
      end
      n_tests++;
      if (recv_ready !== m_rdy) begin
        n_fail++; $display("FAIL model_recv_ready t=%0t got %b want %b", $time, recv_ready, m_rdy);
      end
      n_tests++;
      if (recv_data !== m_data) begin
        n_fail++;
        begin : first_diff
          for (int j = 0; j < int'(CS); j++)
            for (int k = 0; k < int'(W); k++)
              if (recv_data[j][k] !== m_data[j][k]) begin
                $display("FAIL model_recv_data t=%0t [%0d][%0d] got %h want %h",
                         $time, j, k, recv_data[j][k], m_data[j][k]);
                disable first_diff;
              end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Single-precision bits of k + 0.5, built from integer arithmetic.
  function automatic logic [31:0] half_bits(input int k);
    int n = 2 * k + 1;
    int e = 0;
    int mant;
    while ((n >> (e + 1)) != 0) e++;
    mant = (n << (23 - e)) & 32'h007F_FFFF;
    return {1'b0, 8'(126 + e), 23'(mant)};
  endfunction

  function automatic logic [31:0] pat(input int i, input int k);
    return {8'hC0 ^ 8'(i), 8'(k), 16'(i * k + 16'h1234)};
  endfunction

  task automatic clear_inputs();
    send_ready = '0; send_core_idx = '0; send_data = '0;
    recv_request = '0; recv_core_idx = '0;
  endtask

  // sel: 0 = k+0.5, 1 = per-source pattern, 2 = 3.25, 3 = alternate pattern
  task automatic set_send(input int i, input int dst, input int sel);
    send_ready[i] = 1'b1;
    send_core_idx[i] = AW'(dst);
    for (int k = 0; k < int'(W); k++) begin
      case (sel)
        0:       send_data[i][k] = half_bits(k);
        1:       send_data[i][k] = pat(i, k);
        2:       send_data[i][k] = 32'h4050_0000;
        default: send_data[i][k] = pat(i + 8, k);
      endcase
    end
  endtask

  task automatic set_recv(input int j, input int src);
    recv_request[j] = 1'b1;
    recv_core_idx[j] = AW'(src);
  endtask

  task automatic drive_point();
    @(posedge clock); #2;
  endtask

  initial begin
    logic [CS-1:0] acc_ok;
    logic [CS-1:0] acc_rdy;
    logic [4:0]    seen;

    // Reset with random inputs
    reset = 1'b1;
    send_ready = CS'($urandom); recv_request = CS'($urandom);
    for (int i = 0; i < int'(CS); i++) begin
      send_core_idx[i] = AW'($urandom);
      recv_core_idx[i] = AW'($urandom);
      for (int k = 0; k < int'(W); k++) send_data[i][k] = $urandom;
    end
    drive_point();
    reset = 1'b0;
    clear_inputs();
    @(negedge clock);
    chk("reset_send_ok", 32'(send_ok), 32'h0);
    chk("reset_recv_ready", 32'(recv_ready), 32'h0);
    chk("reset_recv_data", 32'(recv_data != '0), 32'h0);
    check_en = 1'b1;

    // Basic transfer 0 -> 5
    drive_point();
    set_send(0, 5, 0); set_recv(5, 0);
    @(posedge clock); @(negedge clock);
    chk("basic_send_ok", 32'(send_ok), 32'h01);
    chk("basic_recv_ready", 32'(recv_ready), 32'h20);
    chk("basic_data0", recv_data[5][0], 32'h3F00_0000);
    chk("basic_data1", recv_data[5][1], 32'h3FC0_0000);
    chk("basic_data63", recv_data[5][63], 32'h427E_0000);
    drive_point();
    clear_inputs();
    @(negedge clock);
    chk("basic_pulse_drop", 32'({send_ok, recv_ready}), 32'h0);

    // Held handshake for 4 cycles: pulses in cycles 1 and 3 only
    drive_point();
    set_send(0, 5, 0); set_recv(5, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      seen[c] = send_ok[0] & recv_ready[5];
      if (c == 1) chk("held_data_c1", recv_data[5][2], 32'h4020_0000);
      if (c == 3) chk("held_data_c3", recv_data[5][2], pat(8, 2));
      @(posedge clock); #2;
      if (c == 1) set_send(0, 5, 3);
      if (c == 3) clear_inputs();
    end
    chk("held_pulse_pattern", 32'(seen), 32'b01010);

    // Mismatch: 1 -> 6 while 6 waits on 2
    set_send(1, 6, 1); set_recv(6, 2);
    acc_ok = '0; acc_rdy = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      acc_ok |= send_ok; acc_rdy |= recv_ready;
    end
    chk("mismatch_quiet", 32'({acc_ok, acc_rdy}), 32'h0);
    drive_point();
    set_send(2, 6, 2);
    @(posedge clock); @(negedge clock);
    chk("mismatch_send_ok", 32'(send_ok), 32'h04);
    chk("mismatch_recv_ready", 32'(recv_ready), 32'h40);
    chk("mismatch_data", recv_data[6][17], 32'h4050_0000);
    drive_point();
    clear_inputs();

    // Parallel pairs plus rejected self-transfer 7 -> 7
    drive_point();
    for (int i = 0; i < 4; i++) begin
      set_send(i, i + 4, 1); set_recv(i + 4, i);
    end
    set_send(7, 7, 3);
    @(posedge clock); @(negedge clock);
    chk("par_send_ok", 32'(send_ok), 32'h0F);
    chk("par_recv_ready", 32'(recv_ready), 32'hF0);
    for (int i = 0; i < 4; i++) chk("par_data", recv_data[i + 4][i + 9], pat(i, i + 9));
    drive_point();
    clear_inputs();

    // Accepted self-transfer 7 -> 7
    drive_point();
    set_send(7, 7, 3); set_recv(7, 7);
    @(posedge clock); @(negedge clock);
    chk("self_flags", 32'({send_ok, recv_ready}), 32'h8080);
    chk("self_data", recv_data[7][5], pat(15, 5));
    drive_point();
    clear_inputs();

    // Reset in the same cycle as a match drops it
    drive_point();
    reset = 1'b1;
    set_send(3, 1, 1); set_recv(1, 3);
    @(posedge clock); @(negedge clock);
    chk("rst_mid_flags", 32'({send_ok, recv_ready}), 32'h0);
    chk("rst_mid_data", 32'(recv_data != '0), 32'h0);
    drive_point();
    reset = 1'b0;
    @(posedge clock); @(negedge clock);
    chk("post_rst_send_ok", 32'(send_ok), 32'h08);
    chk("post_rst_recv_ready", 32'(recv_ready), 32'h02);
    chk("post_rst_data", recv_data[1][40], pat(3, 40));
    drive_point();
    clear_inputs();
    repeat (3) @(negedge clock);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
